fetch_pc_unit: RTL and testbench

- Instruction-fetch front end that holds the architectural PC register.
- Consumes the selected next-PC produced by the PC-select mux and returns the sequential candidate (PC+4) to it.
- Issues one instruction-memory request at a time over a valid/ready handshake.
- Buffers the returned instruction with its PC for the decode/execute stage and discards in-flight fetches on redirect.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_pc_unit_if.sv | 33 +++
 rtl/fetch_pc_unit.sv | 95 +++++++++
 tb/tb_fetch_pc_unit.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
//==============================================================================
// fetch_pkg - shared types and constants for the fetch front end | rev 1.0
//==============================================================================
`default_nettype none

package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] INST_NOP         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/fetch_pc_unit_if.sv
//==============================================================================
// fetch_pc_unit_if - instruction-memory and decode-side handshake bundle | rev 1.0
//==============================================================================
`default_nettype none

interface fetch_pc_unit_if #(
  parameter int XLEN = 32
);

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            if_valid;
  logic [31:0]     if_inst;
  logic [XLEN-1:0] if_pc;
  logic            id_ready;

  // master is the fetch unit; slave is the memory/decode environment
  modport master (
    output imem_req_valid, imem_addr, if_valid, if_inst, if_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, if_valid, if_inst, if_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready
  );

endinterface

`default_nettype wire

// File: rtl/fetch_pc_unit.sv
//==============================================================================
// fetch_pc_unit - PC register and single-outstanding instruction fetch | rev 1.0
//==============================================================================
`default_nettype none

module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  wire logic            clk,
  input  wire logic            rst,
  input  wire logic [XLEN-1:0] pc_next,
  input  wire logic            redirect,
  output logic [XLEN-1:0]      pc_plus4,
  fetch_pc_unit_if.master      bus
);

  fetch_state_e    state;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] req_pc_q;
  logic [XLEN-1:0] pc_load;
  logic            drop_q;
  logic            if_valid_q;
  logic [31:0]     if_inst_q;
  logic [XLEN-1:0] if_pc_q;

  assign pc_load  = {pc_next[XLEN-1:2], 2'b00};
  assign pc_plus4 = pc_q + XLEN'(4);

  assign bus.imem_req_valid = (state == S_REQ) && !redirect;
  assign bus.imem_addr      = pc_q;
  assign bus.if_valid       = if_valid_q;
  assign bus.if_inst        = if_inst_q;
  assign bus.if_pc          = if_pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_REQ;
      pc_q       <= RESET_PC;
      req_pc_q   <= RESET_PC;
      drop_q     <= 1'b0;
      if_valid_q <= 1'b0;
      if_inst_q  <= INST_NOP;
      if_pc_q    <= RESET_PC;
    end else begin
      case (state)
        S_REQ: begin
          if (redirect) begin
            pc_q <= pc_load;
          end else if (bus.imem_req_ready) begin
            req_pc_q <= pc_q;
            pc_q     <= pc_load;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (redirect) begin
            pc_q <= pc_load;
          end
          // a redirect seen before or alongside the response kills it
          if (bus.imem_rsp_valid) begin
            drop_q <= 1'b0;
            if (!drop_q && !redirect) begin
              if_inst_q  <= bus.imem_rsp_data;
              if_pc_q    <= req_pc_q;
              if_valid_q <= 1'b1;
              state      <= S_HOLD;
            end else begin
              state <= S_REQ;
            end
          end else if (redirect) begin
            drop_q <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redirect) begin
            pc_q <= pc_load;
          end
          if (redirect || bus.id_ready) begin
            if_valid_q <= 1'b0;
            state      <= S_REQ;
          end
        end
        default: begin
          state <= S_REQ;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
//==============================================================================
// tb_fetch_pc_unit - directed and randomized checks against a transaction model | rev 1.0
//==============================================================================
`default_nettype none

module tb_fetch_pc_unit;
  import fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] XORMASK = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_next;
  logic        redirect;
  logic [31:0] pc_plus4;

  fetch_pc_unit_if #(.XLEN(32)) bus ();

  fetch_pc_unit #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk      (clk),
    .rst      (rst),
    .pc_next  (pc_next),
    .redirect (redirect),
    .pc_plus4 (pc_plus4),
    .bus      (bus.master)
  );

  always #5 clk = ~clk;

  // Transaction-level model: architectural PC, one outstanding fetch, held instruction
  logic [31:0] m_pc, m_hold_pc, m_hold_inst, m_mem_addr;
  bit          m_busy, m_killed, m_holding, m_mem_pend, chk_en;
  int          m_mem_cnt;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc        = RST_PC;
    m_busy      = 1'b0;
    m_killed    = 1'b0;
    m_holding   = 1'b0;
    m_mem_pend  = 1'b0;
    m_mem_cnt   = 0;
    m_hold_inst = INST_NOP;
    m_hold_pc   = RST_PC;
    m_mem_addr  = RST_PC;
  endtask

  // One clock cycle: drive, check mid-cycle, then advance the model at the edge
  task automatic cycle(input bit r, input bit redir, input bit seq, input logic [31:0] tgt,
                       input bit rdy, input bit idr, input int dly);
    logic [31:0] pn;
    bit mrsp, fire, kill;
    pn   = seq ? m_pc + 32'd4 : tgt;
    mrsp = m_mem_pend && (m_mem_cnt == 0);
    rst                = r;
    redirect           = redir;
    pc_next            = pn;
    bus.imem_req_ready = rdy;
    bus.id_ready       = idr;
    bus.imem_rsp_valid = mrsp;
    bus.imem_rsp_data  = mrsp ? (m_mem_addr ^ XORMASK) : $urandom;
    #3;
    if (chk_en) begin
      chk("imem_addr", bus.imem_addr, m_pc);
      chk("pc_plus4", pc_plus4, m_pc + 32'd4);
      chk("imem_req_valid", 32'(bus.imem_req_valid), 32'(!m_busy && !redir));
      chk("if_valid", 32'(bus.if_valid), 32'(m_holding));
      chk("if_inst", bus.if_inst, m_hold_inst);
      chk("if_pc", bus.if_pc, m_hold_pc);
    end
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      fire = !m_busy && !redir && rdy;
      if (m_busy && !m_holding) begin
        kill = m_killed || redir;
        if (mrsp) begin
          m_mem_pend = 1'b0;
          m_killed   = 1'b0;
          if (kill) begin
            m_busy = 1'b0;
          end else begin
            m_holding   = 1'b1;
            m_hold_pc   = m_mem_addr;
            m_hold_inst = m_mem_addr ^ XORMASK;
          end
        end else begin
          if (redir) m_killed = 1'b1;
          if (m_mem_cnt > 0) m_mem_cnt--;
        end
      end else if (m_holding) begin
        if (idr || redir) begin
          m_holding = 1'b0;
          m_busy    = 1'b0;
        end
      end
      if (fire) begin
        m_busy     = 1'b1;
        m_killed   = 1'b0;
        m_mem_pend = 1'b1;
        m_mem_addr = m_pc;
        m_mem_cnt  = dly;
      end
      if (redir || fire) m_pc = pn & ~32'd3;
    end
    #1;
  endtask

  initial begin
    model_reset();
    chk_en = 1'b0;
    cycle(1, 0, 1, 0, 1, 1, 0);
    chk_en = 1'b1;
    cycle(1, 0, 1, 0, 1, 1, 0);

    // zero-wait sequential fetch: 0,4,8 one instruction every 3 cycles
    repeat (9) cycle(0, 0, 1, 0, 1, 1, 0);

    // decode stall for 5 cycles while holding
    cycle(0, 0, 1, 0, 1, 0, 0);
    cycle(0, 0, 1, 0, 1, 0, 0);
    repeat (5) cycle(0, 0, 1, 0, 1, 0, 0);
    repeat (3) cycle(0, 0, 1, 0, 1, 1, 0);

    // redirect while waiting on a slow response
    cycle(0, 0, 1, 0, 1, 1, 3);
    cycle(0, 1, 0, 32'h0000_0100, 1, 1, 0);
    repeat (8) cycle(0, 0, 1, 0, 1, 1, 0);

    // redirect in the same cycle as the response
    cycle(0, 0, 1, 0, 1, 1, 0);
    cycle(0, 1, 0, 32'h0000_0200, 1, 1, 0);
    repeat (3) cycle(0, 0, 1, 0, 1, 1, 0);

    // top-of-address-space wrap, with unaligned target bits dropped
    cycle(0, 1, 0, 32'hFFFF_FFFF, 1, 1, 0);
    repeat (6) cycle(0, 0, 1, 0, 1, 1, 0);

    // reset while a request is outstanding
    cycle(0, 0, 1, 0, 1, 1, 3);
    cycle(0, 0, 1, 0, 1, 1, 0);
    cycle(1, 0, 1, 0, 1, 1, 0);
    repeat (4) cycle(0, 0, 1, 0, 1, 1, 0);

    // back-to-back redirects during a wait
    cycle(0, 0, 1, 0, 1, 1, 2);
    cycle(0, 1, 0, 32'h0000_0400, 1, 1, 0);
    cycle(0, 1, 0, 32'h0000_0800, 1, 1, 0);
    repeat (6) cycle(0, 0, 1, 0, 1, 1, 0);

    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 99) == 0),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 3) != 0),
            $urandom,
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 3) != 0),
            int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
